// File: rtl/vx_fetch_sched.sv
// vx_fetch_sched: per-core warp fetch scheduler, round-robin over READY warps,
// one outstanding fetch per warp. Define VX_FETCH_SCHED_PERF_EN for perf counters.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 16
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_fetch_sched #(
    parameter int unsigned       CORE_ID    = 0,
    parameter int unsigned       THREAD_CNT = `NUM_THREADS,
    parameter int unsigned       WARP_CNT   = `NUM_WARPS,
    parameter logic [`XLEN-1:0]  STARTUP_PC = `XLEN'(32'h80000000)
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    spawn_valid,
    input  logic [`NW_WIDTH-1:0]    spawn_wid,
    input  logic [`XLEN-1:0]        spawn_pc,
    input  logic [THREAD_CNT-1:0]   spawn_tmask,

    input  logic                    unlock_valid,
    input  logic [`NW_WIDTH-1:0]    unlock_wid,
    input  logic                    unlock_halt,
    input  logic [`XLEN-1:0]        unlock_pc,
    input  logic [THREAD_CNT-1:0]   unlock_tmask,

    output logic                    sched_valid,
    input  logic                    sched_ready,
    output logic [`NW_WIDTH-1:0]    sched_wid,
    output logic [`XLEN-1:0]        sched_pc,
    output logic [THREAD_CNT-1:0]   sched_tmask,
    output logic [`UUID_WIDTH-1:0]  sched_uuid,

    output logic [WARP_CNT-1:0]     active_warps,
    output logic                    busy
`ifdef VX_FETCH_SCHED_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0] perf_idle_cycles,
    output logic [`PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);

    localparam int unsigned NW = `NW_WIDTH;
    localparam int unsigned XW = `XLEN;
    localparam int unsigned UW = `UUID_WIDTH;

    typedef enum logic [1:0] {
        WS_IDLE    = 2'd0,
        WS_READY   = 2'd1,
        WS_PENDING = 2'd2
    } warp_state_e;

    warp_state_e            state_q [WARP_CNT];
    warp_state_e            state_d [WARP_CNT];
    logic [XW-1:0]          pc_q    [WARP_CNT];
    logic [XW-1:0]          pc_d    [WARP_CNT];
    logic [THREAD_CNT-1:0]  tmask_q [WARP_CNT];
    logic [THREAD_CNT-1:0]  tmask_d [WARP_CNT];

    logic [NW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [UW-1:0]          uuid_cnt_q, uuid_cnt_d;

    logic                   valid_d;
    logic [NW-1:0]          wid_d;
    logic [XW-1:0]          pc_out_d;
    logic [THREAD_CNT-1:0]  tmask_out_d;
    logic [UW-1:0]          uuid_d;
    logic [WARP_CNT-1:0]    active_d;
    logic                   busy_d;

    logic                   load_en;
    logic                   sel_found;
    logic [NW-1:0]          sel_wid;
    logic [NW-1:0]          scan_wid;

    // State register: warp 0 boots READY, all others IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WARP_CNT; w++) begin
                state_q[w] <= (w == 0) ? WS_READY : WS_IDLE;
                pc_q[w]    <= (w == 0) ? STARTUP_PC : XW'(0);
                tmask_q[w] <= (w == 0) ? THREAD_CNT'(1) : THREAD_CNT'(0);
            end
            rr_ptr_q     <= '0;
            uuid_cnt_q   <= '0;
            sched_valid  <= 1'b0;
            sched_wid    <= '0;
            sched_pc     <= '0;
            sched_tmask  <= '0;
            sched_uuid   <= '0;
            active_warps <= WARP_CNT'(1);
            busy         <= 1'b1;
        end else begin
            for (int w = 0; w < WARP_CNT; w++) begin
                state_q[w] <= state_d[w];
                pc_q[w]    <= pc_d[w];
                tmask_q[w] <= tmask_d[w];
            end
            rr_ptr_q     <= rr_ptr_d;
            uuid_cnt_q   <= uuid_cnt_d;
            sched_valid  <= valid_d;
            sched_wid    <= wid_d;
            sched_pc     <= pc_out_d;
            sched_tmask  <= tmask_out_d;
            sched_uuid   <= uuid_d;
            active_warps <= active_d;
            busy         <= busy_d;
        end
    end

    // Next-state: select, unlock and spawn touch disjoint warp states, so no priority is needed.
    always_comb begin
        for (int w = 0; w < WARP_CNT; w++) begin
            state_d[w] = state_q[w];
            pc_d[w]    = pc_q[w];
            tmask_d[w] = tmask_q[w];
        end
        rr_ptr_d    = rr_ptr_q;
        uuid_cnt_d  = uuid_cnt_q;
        valid_d     = sched_valid;
        wid_d       = sched_wid;
        pc_out_d    = sched_pc;
        tmask_out_d = sched_tmask;
        uuid_d      = sched_uuid;
        sel_found   = 1'b0;
        sel_wid     = '0;
        scan_wid    = '0;
        active_d    = '0;
        busy_d      = 1'b0;

        for (int i = 0; i < WARP_CNT; i++) begin
            scan_wid = rr_ptr_q + NW'(i);
            if (!sel_found && state_q[scan_wid] == WS_READY) begin
                sel_found = 1'b1;
                sel_wid   = scan_wid;
            end
        end

        load_en = !sched_valid || sched_ready;
        if (load_en) begin
            valid_d = sel_found;
            if (sel_found) begin
                wid_d            = sel_wid;
                pc_out_d         = pc_q[sel_wid];
                tmask_out_d      = tmask_q[sel_wid];
                uuid_d           = uuid_cnt_q;
                uuid_cnt_d       = uuid_cnt_q + UW'(1);
                rr_ptr_d         = sel_wid + NW'(1);
                state_d[sel_wid] = WS_PENDING;
            end
        end

        if (unlock_valid && state_q[unlock_wid] == WS_PENDING) begin
            if (unlock_halt || unlock_tmask == '0) begin
                state_d[unlock_wid] = WS_IDLE;
            end else begin
                state_d[unlock_wid] = WS_READY;
                pc_d[unlock_wid]    = unlock_pc;
                tmask_d[unlock_wid] = unlock_tmask;
            end
        end

        if (spawn_valid && state_q[spawn_wid] == WS_IDLE && spawn_tmask != '0) begin
            state_d[spawn_wid] = WS_READY;
            pc_d[spawn_wid]    = spawn_pc;
            tmask_d[spawn_wid] = spawn_tmask;
        end

        for (int w = 0; w < WARP_CNT; w++) begin
            active_d[w] = (state_d[w] != WS_IDLE);
        end
        busy_d = |active_d;
    end

`ifdef VX_FETCH_SCHED_PERF_EN
    // Idle: live warps exist but none can issue; stall: fetch stage back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_idle_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !sel_found && !sched_valid) begin
                perf_idle_cycles <= perf_idle_cycles + `PERF_CTR_BITS'(1);
            end
            if (sched_valid && !sched_ready) begin
                perf_stall_cycles <= perf_stall_cycles + `PERF_CTR_BITS'(1);
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && unlock_valid) begin
            assert (state_q[unlock_wid] == WS_PENDING)
                else $error("vx_fetch_sched[%0d]: unlock of non-pending warp %0d", CORE_ID, unlock_wid);
        end
    end
`endif

endmodule

// File: tb/tb_vx_fetch_sched.sv
// Scoreboard bench for vx_fetch_sched: expected grants queued at stimulus, popped on each fire.
module tb_vx_fetch_sched;

    localparam int unsigned NW = 2;
    localparam int unsigned TC = 4;
    localparam int unsigned WC = 4;
    localparam int unsigned XW = 32;
    localparam int unsigned UW = 16;

    typedef struct {
        logic [NW-1:0] wid;
        logic [XW-1:0] pc;
        logic [TC-1:0] tmask;
        logic [UW-1:0] uuid;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          spawn_valid;
    logic [NW-1:0] spawn_wid;
    logic [XW-1:0] spawn_pc;
    logic [TC-1:0] spawn_tmask;
    logic          unlock_valid;
    logic [NW-1:0] unlock_wid;
    logic          unlock_halt;
    logic [XW-1:0] unlock_pc;
    logic [TC-1:0] unlock_tmask;
    logic          sched_valid;
    logic          sched_ready;
    logic [NW-1:0] sched_wid;
    logic [XW-1:0] sched_pc;
    logic [TC-1:0] sched_tmask;
    logic [UW-1:0] sched_uuid;
    logic [WC-1:0] active_warps;
    logic          busy;
`ifdef VX_FETCH_SCHED_PERF_EN
    logic [43:0]   perf_idle_cycles;
    logic [43:0]   perf_stall_cycles;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    vx_fetch_sched #(
        .CORE_ID    (0),
        .THREAD_CNT (TC),
        .WARP_CNT   (WC),
        .STARTUP_PC (32'h80000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spawn_valid  (spawn_valid),
        .spawn_wid    (spawn_wid),
        .spawn_pc     (spawn_pc),
        .spawn_tmask  (spawn_tmask),
        .unlock_valid (unlock_valid),
        .unlock_wid   (unlock_wid),
        .unlock_halt  (unlock_halt),
        .unlock_pc    (unlock_pc),
        .unlock_tmask (unlock_tmask),
        .sched_valid  (sched_valid),
        .sched_ready  (sched_ready),
        .sched_wid    (sched_wid),
        .sched_pc     (sched_pc),
        .sched_tmask  (sched_tmask),
        .sched_uuid   (sched_uuid),
        .active_warps (active_warps),
        .busy         (busy)
`ifdef VX_FETCH_SCHED_PERF_EN
        ,
        .perf_idle_cycles  (perf_idle_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [NW-1:0] w, input logic [XW-1:0] pc,
                            input logic [TC-1:0] tm, input logic [UW-1:0] id);
        exp_t e;
        e.wid = w; e.pc = pc; e.tmask = tm; e.uuid = id;
        sb_q.push_back(e);
    endtask

    task automatic clr_in();
        spawn_valid  = 1'b0;
        unlock_valid = 1'b0;
        unlock_halt  = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        clr_in();
    endtask

    task automatic do_spawn(input logic [NW-1:0] w, input logic [XW-1:0] pc, input logic [TC-1:0] tm);
        spawn_valid = 1'b1; spawn_wid = w; spawn_pc = pc; spawn_tmask = tm;
    endtask

    task automatic do_unlock(input logic [NW-1:0] w, input logic [XW-1:0] pc,
                             input logic [TC-1:0] tm, input logic halt);
        unlock_valid = 1'b1; unlock_wid = w; unlock_pc = pc; unlock_tmask = tm; unlock_halt = halt;
    endtask

    task automatic chk_hold();
        chk("hold_valid", 64'(sched_valid), 64'(1));
        chk("hold_wid",   64'(sched_wid),   64'(1));
        chk("hold_pc",    64'(sched_pc),    64'(32'h104));
        chk("hold_uuid",  64'(sched_uuid),  64'(5));
    endtask

    task automatic chk_active(input string tag, input logic [WC-1:0] a, input logic b);
        chk(tag,      64'(active_warps), 64'(a));
        chk("busy",   64'(busy),         64'(b));
    endtask

    // Grant monitor: samples just before the edge at which the handshake completes.
    always begin
        @(negedge clk);
        #4;
        if (reset && sched_valid && sched_ready) begin
            chk("grant_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("grant_wid",   64'(sched_wid),   64'(mon_e.wid));
                chk("grant_pc",    64'(sched_pc),    64'(mon_e.pc));
                chk("grant_tmask", 64'(sched_tmask), 64'(mon_e.tmask));
                chk("grant_uuid",  64'(sched_uuid),  64'(mon_e.uuid));
            end
        end
    end

    initial begin
        reset = 1'b1;
        sched_ready = 1'b1;
        clr_in();
        spawn_wid = '0; spawn_pc = '0; spawn_tmask = '0;
        unlock_wid = '0; unlock_pc = '0; unlock_tmask = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid", 64'(sched_valid), 64'(0));
        chk("rst_wid",   64'(sched_wid),   64'(0));
        chk("rst_pc",    64'(sched_pc),    64'(0));
        chk("rst_tmask", 64'(sched_tmask), 64'(0));
        chk("rst_uuid",  64'(sched_uuid),  64'(0));
        chk_active("rst_active", 4'b0001, 1'b1);

        // Boot: warp 0 fetched once, then nothing until it is unlocked.
        push_exp(0, 32'h80000000, 4'h1, 0);
        reset = 1'b1;
        repeat (4) cyc();
        chk("boot_one_shot", 64'(sched_valid), 64'(0));
        chk_active("boot_active", 4'b0001, 1'b1);

        // Spawns under back-pressure, then sustained round-robin drain.
        push_exp(1, 32'h100, 4'hF, 1);
        push_exp(2, 32'h200, 4'hF, 2);
        push_exp(3, 32'h300, 4'hF, 3);
        push_exp(0, 32'h80000004, 4'h1, 4);
        sched_ready = 1'b0;
        do_spawn(1, 32'h100, 4'hF); cyc();
        do_spawn(2, 32'h200, 4'hF); cyc();
        do_spawn(3, 32'h300, 4'hF); cyc();
        do_unlock(0, 32'h80000004, 4'h1, 1'b0); cyc();
        sched_ready = 1'b1; cyc();
        repeat (3) cyc();
        chk("drain_p2", 64'(sched_valid), 64'(0));

        // Hold with ready warps behind a stalled request; ignored spawns to busy warps.
        push_exp(1, 32'h104, 4'hF, 5);
        push_exp(2, 32'h204, 4'hF, 6);
        push_exp(3, 32'h304, 4'hF, 7);
        sched_ready = 1'b0;
        do_unlock(1, 32'h104, 4'hF, 1'b0); cyc();
        do_unlock(2, 32'h204, 4'hF, 1'b0); cyc();
        chk_hold(); do_unlock(3, 32'h304, 4'hF, 1'b0); cyc();
        chk_hold(); do_spawn(0, 32'hBAD, 4'hF); cyc();
        chk_hold(); do_spawn(3, 32'hBAD, 4'h3); cyc();
        chk_hold(); cyc();
        chk_hold(); cyc();
        chk_hold(); sched_ready = 1'b1; cyc();
        cyc(); cyc();
        chk("drain_p3", 64'(sched_valid), 64'(0));

        // Halts, tmask==0 termination, simultaneous spawn+unlock, spawn with empty mask.
        do_unlock(1, 32'hBAD, 4'hF, 1'b1); cyc();
        chk_active("halt_w1", 4'b1101, 1'b1);
        push_exp(0, 32'h80000010, 4'h1, 8);
        do_unlock(0, 32'h80000010, 4'h1, 1'b0); do_spawn(0, 32'hBAD, 4'hF); cyc();
        cyc(); cyc();
        do_unlock(0, 32'h80000020, 4'h0, 1'b0); cyc();
        chk_active("halt_w0", 4'b1100, 1'b1);
        do_unlock(2, 32'hBAD, 4'hF, 1'b1); cyc();
        chk_active("halt_w2", 4'b1000, 1'b1);
        do_unlock(3, 32'hBAD, 4'hF, 1'b1); cyc();
        chk_active("all_halt", 4'b0000, 1'b0);
        do_spawn(1, 32'h1000, 4'h0); cyc();
        chk_active("spawn_zero_mask", 4'b0000, 1'b0);
        push_exp(1, 32'h1000, 4'h5, 9);
        do_spawn(1, 32'h1000, 4'h5); cyc();
        chk_active("respawn_w1", 4'b0010, 1'b1);
        cyc(); cyc(); cyc();

        // Reset while a request is held.
        sched_ready = 1'b0;
        do_unlock(1, 32'h1004, 4'h5, 1'b0); cyc();
        cyc();
        chk("held_valid", 64'(sched_valid), 64'(1));
        chk("held_wid",   64'(sched_wid),   64'(1));
        chk("held_uuid",  64'(sched_uuid),  64'(10));
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(sched_valid), 64'(0));
        chk("mid_rst_uuid",  64'(sched_uuid),  64'(0));
        chk("mid_rst_pc",    64'(sched_pc),    64'(0));
        chk_active("mid_rst_active", 4'b0001, 1'b1);
        sched_ready = 1'b1;
        push_exp(0, 32'h80000000, 4'h1, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cyc();

        chk("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vx_fetch_sched.md
# VX_fetch_sched

Per-core warp fetch scheduler that sits in front of the instruction fetch stage and drives its schedule handshake. Holds PC/thread-mask state per warp, allows at most one outstanding fetch per warp, and picks among eligible warps round-robin. Warps are started by spawn requests and re-enabled or terminated by unlock events from decode/branch resolution.

## Interface
- CORE_ID, 0, core index (trace only)
- THREAD_CNT, `NUM_THREADS, threads per warp
- WARP_CNT, `NUM_WARPS, warps per core (power of 2, >=2)
- STARTUP_PC, 32'h80000000, boot PC of warp 0
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- spawn_valid  in  1  start an idle warp
- spawn_wid  in  `NW_WIDTH  warp to start
- spawn_pc  in  `XLEN  start PC
- spawn_tmask  in  THREAD_CNT  start thread mask
- unlock_valid  in  1  fetched instruction of a pending warp resolved
- unlock_wid  in  `NW_WIDTH  warp resolved
- unlock_halt  in  1  warp terminates
- unlock_pc  in  `XLEN  next PC
- unlock_tmask  in  THREAD_CNT  next thread mask
- sched_valid  out  1  fetch request valid
- sched_ready  in  1  fetch stage accepts
- sched_wid  out  `NW_WIDTH  request warp
- sched_pc  out  `XLEN  request PC
- sched_tmask  out  THREAD_CNT  request thread mask
- sched_uuid  out  `UUID_WIDTH  request sequence id
- active_warps  out  WARP_CNT  bit w set when warp w not IDLE
- busy  out  1  OR of active_warps

## Operation
- Per-warp state: IDLE, READY, PENDING; plus PC and tmask registers.
- Reset: warp 0 READY, PC=STARTUP_PC, tmask=1 (lane 0 only); others IDLE, PC=0, tmask=0.
- Spawn: IDLE warp -> READY with spawn_pc/spawn_tmask. Spawn to non-IDLE warp ignored. spawn_tmask==0 ignored.
- Select: round-robin over READY warps; priority starts at last granted wid+1 mod WARP_CNT (pointer resets to 0). Selected warp loads output register and moves READY -> PENDING in same cycle.
- Unlock: PENDING warp -> READY with unlock_pc/unlock_tmask; if unlock_halt or unlock_tmask==0 -> IDLE. Unlock of non-PENDING warp ignored (runtime assert in simulation).
- sched_uuid: counter, increments on each load of the output register, wraps modulo 2^`UUID_WIDTH.
- Simultaneous spawn and unlock to same wid: unlock applies, spawn dropped (warp not IDLE).

## Timing
- Output register: warp selected in cycle N appears on sched_* in N+1.
- Output register loads when empty or firing (sched_valid && sched_ready) in the same cycle; sustained 1 request/cycle when >=2 warps READY.
- sched_* stable while sched_valid && !sched_ready; sched_valid never drops without fire.
- Unlock in cycle N: warp eligible for selection in N+1 (earliest sched_valid for it at N+2). Same for spawn.
- Reset values: sched_valid=0, sched_wid/pc/tmask/uuid=0, active_warps=1, busy=1.
- Reset mid-operation: all state cleared asynchronously, held request dropped, uuid=0.

## Configuration
- VX_FETCH_SCHED_PERF_EN: adds outputs perf_idle_cycles and perf_stall_cycles (`PERF_CTR_BITS each, reset 0). idle increments when busy && no warp READY && !sched_valid; stall increments when sched_valid && !sched_ready. Without macro: ports and counters absent, no other behaviour change.

## Test plan
- Reset release, sched_ready=1 -> cycle 1: sched_valid=1, wid=0, pc=0x80000000, tmask=1, uuid=0; no further request until unlock.
- Spawn wid 1,2,3 (pc 0x100,0x200,0x300, tmask all-ones), warp 0 unlocked at each fire -> grants in order 0,1,2,3,0 with uuid 0..4 consecutive, one per cycle.
- Hold sched_ready=0 for 5 cycles with warps 1,2 READY -> wid/pc/uuid unchanged; after release, next grant wid 2 next cycle.
- Unlock wid 1 with unlock_halt=1 -> active_warps bit1 clears next cycle; warp 1 never granted; busy=0 after all warps halt.
- Unlock to READY warp and spawn to PENDING warp -> state, PC, tmask unchanged; assert fires for unlock.
- Assert reset with sched_valid=1 -> sched_valid=0 immediately; after release warp 0 at STARTUP_PC, uuid=0.
